// File: rtl/ibex_rvfi_trace_buf.sv
// RVFI retirement trace FIFO: buffers 166-bit retirement records for a valid/ready sink, counts drops.
// Define RVFI_TRACE_ORDER_CHECK_EN to enable the sticky rvfi_order sequence checker.
module ibex_rvfi_trace_buf #(
   parameter int unsigned DEPTH = 4
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic                    rvfi_valid_i,
   input  logic [63:0]             rvfi_order_i,
   input  logic [31:0]             rvfi_insn_i,
   input  logic                    rvfi_trap_i,
   input  logic [31:0]             rvfi_pc_rdata_i,
   input  logic [4:0]              rvfi_rd_addr_i,
   input  logic [31:0]             rvfi_rd_wdata_i,
   output logic                    trace_valid_o,
   input  logic                    trace_ready_i,
   output logic [165:0]            trace_rec_o,
   output logic [$clog2(DEPTH):0]  level_o,
   output logic [15:0]             drop_cnt_o,
   output logic                    order_err_o
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned LVL_W = PTR_W + 1;
   localparam int unsigned REC_W = 166;

   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
   localparam logic [LVL_W-1:0] LVL_ONE  = LVL_W'(1);
   localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);
   localparam logic [LVL_W-1:0] LVL_ZERO = LVL_W'(0);

   logic [REC_W-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0] level_q, level_d;
   logic             valid_q, valid_d;
   logic [15:0]      drop_cnt_q, drop_cnt_d;

   logic             full_s;
   logic             pop_s;
   logic             push_s;
   logic             drop_s;
   logic [REC_W-1:0] rec_in_s;

   // A full FIFO still accepts a push when the head leaves in the same cycle.
   always_comb begin
      rec_in_s = {rvfi_order_i, rvfi_insn_i, rvfi_trap_i, rvfi_pc_rdata_i,
                  rvfi_rd_addr_i, rvfi_rd_wdata_i};
      full_s   = (level_q == LVL_FULL);
      pop_s    = valid_q & trace_ready_i;
      push_s   = rvfi_valid_i & (~full_s | pop_s);
      drop_s   = rvfi_valid_i & full_s & ~pop_s;
   end

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      level_d    = level_q;
      drop_cnt_d = drop_cnt_q;

      if (push_s) begin
         wr_ptr_d = wr_ptr_q + PTR_ONE;
      end else begin
         wr_ptr_d = wr_ptr_q;
      end

      if (pop_s) begin
         rd_ptr_d = rd_ptr_q + PTR_ONE;
      end else begin
         rd_ptr_d = rd_ptr_q;
      end

      case ({push_s, pop_s})
         2'b10:   level_d = level_q + LVL_ONE;
         2'b01:   level_d = level_q - LVL_ONE;
         default: level_d = level_q;
      endcase

      if (drop_s && (drop_cnt_q != 16'hFFFF)) begin
         drop_cnt_d = drop_cnt_q + 16'd1;
      end else begin
         drop_cnt_d = drop_cnt_q;
      end

      valid_d = (level_d != LVL_ZERO);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q   <= PTR_W'(0);
         rd_ptr_q   <= PTR_W'(0);
         level_q    <= LVL_ZERO;
         valid_q    <= 1'b0;
         drop_cnt_q <= 16'd0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         level_q    <= level_d;
         valid_q    <= valid_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   // Storage is intentionally unreset; the head is only meaningful while valid.
   always_ff @(posedge clk_i) begin
      if (push_s) begin
         mem_q[wr_ptr_q] <= rec_in_s;
      end
   end

   assign trace_valid_o = valid_q;
   assign trace_rec_o   = mem_q[rd_ptr_q];
   assign level_o       = level_q;
   assign drop_cnt_o    = drop_cnt_q;

`ifdef RVFI_TRACE_ORDER_CHECK_EN
   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_TRACK = 1'b1
   } ord_state_e;

   ord_state_e  state_q, state_d;
   logic [63:0] last_order_q, last_order_d;
   logic        order_err_q, order_err_d;

   // Every retirement is checked, including ones the FIFO drops.
   always_comb begin
      state_d      = state_q;
      last_order_d = last_order_q;
      order_err_d  = order_err_q;
      case (state_q)
         ST_IDLE: begin
            if (rvfi_valid_i) begin
               state_d      = ST_TRACK;
               last_order_d = rvfi_order_i;
            end else begin
               state_d      = ST_IDLE;
            end
         end
         ST_TRACK: begin
            if (rvfi_valid_i) begin
               last_order_d = rvfi_order_i;
               if (rvfi_order_i != (last_order_q + 64'd1)) begin
                  order_err_d = 1'b1;
               end else begin
                  order_err_d = order_err_q;
               end
            end else begin
               last_order_d = last_order_q;
            end
         end
         default: begin
            state_d      = ST_IDLE;
            last_order_d = 64'd0;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= ST_IDLE;
         last_order_q <= 64'd0;
         order_err_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         last_order_q <= last_order_d;
         order_err_q  <= order_err_d;
      end
   end

   assign order_err_o = order_err_q;
`else
   assign order_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_ibex_rvfi_trace_buf.sv
// Self-checking bench for ibex_rvfi_trace_buf: vector table, corner sequences, random run vs queue model.
module tb_ibex_rvfi_trace_buf;

   localparam int DEPTH = 4;
`ifdef RVFI_TRACE_ORDER_CHECK_EN
   localparam bit CHK_EN = 1'b1;
`else
   localparam bit CHK_EN = 1'b0;
`endif

   logic         clk_i;
   logic         rst_ni;
   logic         rvfi_valid_i;
   logic [63:0]  rvfi_order_i;
   logic [31:0]  rvfi_insn_i;
   logic         rvfi_trap_i;
   logic [31:0]  rvfi_pc_rdata_i;
   logic [4:0]   rvfi_rd_addr_i;
   logic [31:0]  rvfi_rd_wdata_i;
   logic         trace_valid_o;
   logic         trace_ready_i;
   logic [165:0] trace_rec_o;
   logic [2:0]   level_o;
   logic [15:0]  drop_cnt_o;
   logic         order_err_o;

   int n_err = 0;
   int n_chk = 0;

   ibex_rvfi_trace_buf #(.DEPTH(DEPTH)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .rvfi_valid_i(rvfi_valid_i), .rvfi_order_i(rvfi_order_i),
      .rvfi_insn_i(rvfi_insn_i), .rvfi_trap_i(rvfi_trap_i),
      .rvfi_pc_rdata_i(rvfi_pc_rdata_i), .rvfi_rd_addr_i(rvfi_rd_addr_i),
      .rvfi_rd_wdata_i(rvfi_rd_wdata_i),
      .trace_valid_o(trace_valid_o), .trace_ready_i(trace_ready_i),
      .trace_rec_o(trace_rec_o), .level_o(level_o),
      .drop_cnt_o(drop_cnt_o), .order_err_o(order_err_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   typedef struct {
      logic        v;
      logic [63:0] ord;
      logic        rdy;
      logic [2:0]  lvl;
      logic [15:0] drop;
      logic [63:0] head;
   } vec_t;

   vec_t tbl [14];

   function automatic logic [165:0] mk_rec(input logic [63:0] ord);
      logic [31:0] lo;
      lo = ord[31:0];
      return {ord, lo ^ 32'h1357_9BDF, lo[0], (lo << 2) + 32'h8000_0000, lo[4:0], ~lo};
   endfunction

   function automatic logic [165:0] rnd_rec(input logic [63:0] ord);
      logic [31:0] a, b, c, d;
      a = $urandom; b = $urandom; c = $urandom; d = $urandom;
      return {ord, a, b[0], c, b[5:1], d};
   endfunction

   task automatic chk(input string nm, input logic [165:0] act, input logic [165:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   task automatic cyc(input logic v, input logic [165:0] rec, input logic rdy);
      @(negedge clk_i);
      rvfi_valid_i = v;
      {rvfi_order_i, rvfi_insn_i, rvfi_trap_i, rvfi_pc_rdata_i, rvfi_rd_addr_i, rvfi_rd_wdata_i} = rec;
      trace_ready_i = rdy;
      @(posedge clk_i);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk_i);
      rvfi_valid_i  = 1'b0;
      trace_ready_i = 1'b0;
      rst_ni        = 1'b0;
      repeat (2) @(posedge clk_i);
      @(negedge clk_i);
      rst_ni = 1'b1;
   endtask

   logic [165:0] mq [$];
   int           m_drop;
   bit           m_have;
   bit           m_err;
   logic [63:0]  m_prev;

   initial begin
      rst_ni = 1'b0;
      rvfi_valid_i = 1'b0;
      trace_ready_i = 1'b0;
      {rvfi_order_i, rvfi_insn_i, rvfi_trap_i, rvfi_pc_rdata_i, rvfi_rd_addr_i, rvfi_rd_wdata_i} = 166'd0;

      // ---- reset state ----
      #12;
      chk("rst_level", 166'(level_o), 166'd0);
      chk("rst_valid", 166'(trace_valid_o), 166'd0);
      chk("rst_drop", 166'(drop_cnt_o), 166'd0);
      chk("rst_err", 166'(order_err_o), 166'd0);
      do_reset();

      // ---- table: fill past full, drop, full push+pop, drain, wrap, level-1 push+pop ----
      tbl[0]  = '{1'b1, 64'd0, 1'b0, 3'd1, 16'd0, 64'd0};
      tbl[1]  = '{1'b1, 64'd1, 1'b0, 3'd2, 16'd0, 64'd0};
      tbl[2]  = '{1'b1, 64'd2, 1'b0, 3'd3, 16'd0, 64'd0};
      tbl[3]  = '{1'b1, 64'd3, 1'b0, 3'd4, 16'd0, 64'd0};
      tbl[4]  = '{1'b1, 64'd4, 1'b0, 3'd4, 16'd1, 64'd0};
      tbl[5]  = '{1'b1, 64'd5, 1'b0, 3'd4, 16'd2, 64'd0};
      tbl[6]  = '{1'b1, 64'd6, 1'b1, 3'd4, 16'd2, 64'd1};
      tbl[7]  = '{1'b0, 64'd0, 1'b1, 3'd3, 16'd2, 64'd2};
      tbl[8]  = '{1'b0, 64'd0, 1'b1, 3'd2, 16'd2, 64'd3};
      tbl[9]  = '{1'b0, 64'd0, 1'b1, 3'd1, 16'd2, 64'd6};
      tbl[10] = '{1'b0, 64'd0, 1'b1, 3'd0, 16'd2, 64'd0};
      tbl[11] = '{1'b1, 64'd7, 1'b1, 3'd1, 16'd2, 64'd7};
      tbl[12] = '{1'b1, 64'd8, 1'b1, 3'd1, 16'd2, 64'd8};
      tbl[13] = '{1'b0, 64'd0, 1'b1, 3'd0, 16'd2, 64'd0};
      for (int i = 0; i < 14; i++) begin
         if (tbl[i].v) begin
            cyc(1'b1, mk_rec(tbl[i].ord), tbl[i].rdy);
         end else begin
            cyc(1'b0, rnd_rec({$urandom, $urandom}), tbl[i].rdy);
         end
         chk($sformatf("tbl%0d_level", i), 166'(level_o), 166'(tbl[i].lvl));
         chk($sformatf("tbl%0d_valid", i), 166'(trace_valid_o), 166'(tbl[i].lvl != 3'd0));
         chk($sformatf("tbl%0d_drop", i), 166'(drop_cnt_o), 166'(tbl[i].drop));
         chk($sformatf("tbl%0d_err", i), 166'(order_err_o), 166'd0);
         if (tbl[i].lvl != 3'd0) chk($sformatf("tbl%0d_head", i), trace_rec_o, mk_rec(tbl[i].head));
      end

      // ---- streaming with ready=1: occupancy never exceeds 1 ----
      do_reset();
      for (int i = 0; i < 3; i++) begin
         cyc(1'b1, mk_rec(64'(i)), 1'b1);
         chk("stream_level", 166'(level_o), 166'd1);
         chk("stream_head", trace_rec_o, mk_rec(64'(i)));
      end
      cyc(1'b0, 166'd0, 1'b1);
      chk("stream_empty", 166'(trace_valid_o), 166'd0);
      chk("stream_err", 166'(order_err_o), 166'd0);

      // ---- order gap 5,6,8 ----
      do_reset();
      cyc(1'b1, mk_rec(64'd5), 1'b1);
      chk("gap_after5", 166'(order_err_o), 166'd0);
      cyc(1'b1, mk_rec(64'd6), 1'b1);
      chk("gap_after6", 166'(order_err_o), 166'd0);
      cyc(1'b1, mk_rec(64'd8), 1'b1);
      chk("gap_after8", 166'(order_err_o), 166'(CHK_EN));
      cyc(1'b1, mk_rec(64'd9), 1'b1);
      cyc(1'b0, 166'd0, 1'b1);
      chk("gap_sticky", 166'(order_err_o), 166'(CHK_EN));

      // ---- mid-cycle reset with two buffered records ----
      do_reset();
      cyc(1'b1, mk_rec(64'd10), 1'b0);
      cyc(1'b1, mk_rec(64'd11), 1'b0);
      chk("mid_pre_level", 166'(level_o), 166'd2);
      #2;
      rvfi_valid_i = 1'b0;
      trace_ready_i = 1'b0;
      rst_ni = 1'b0;
      #1;
      chk("mid_rst_level", 166'(level_o), 166'd0);
      chk("mid_rst_valid", 166'(trace_valid_o), 166'd0);
      @(negedge clk_i);
      rst_ni = 1'b1;
      cyc(1'b1, mk_rec(64'd100), 1'b0);
      chk("mid_post_err", 166'(order_err_o), 166'd0);
      chk("mid_post_level", 166'(level_o), 166'd1);
      chk("mid_post_head", trace_rec_o, mk_rec(64'd100));

      // ---- drop counter saturation ----
      do_reset();
      for (int i = 0; i < 4 + 65534; i++) cyc(1'b1, mk_rec(64'(i)), 1'b0);
      chk("sat_fffe", 166'(drop_cnt_o), 166'(16'hFFFE));
      for (int i = 4 + 65534; i < 70000; i++) cyc(1'b1, mk_rec(64'(i)), 1'b0);
      chk("sat_ffff", 166'(drop_cnt_o), 166'(16'hFFFF));
      chk("sat_level", 166'(level_o), 166'd4);
      chk("sat_head", trace_rec_o, mk_rec(64'd0));
      chk("sat_err", 166'(order_err_o), 166'd0);

      // ---- random run against queue model ----
      do_reset();
      mq.delete();
      m_drop = 0; m_have = 1'b0; m_err = 1'b0; m_prev = 64'd0;
      for (int i = 0; i < 3000; i++) begin
         logic        v, rdy, pop, push;
         logic [63:0] ord;
         logic [165:0] rec;
         v   = ($urandom_range(0, 9) < 7);
         rdy = ($urandom_range(0, 1) == 1);
         if (!m_have) ord = {$urandom, $urandom};
         else if ($urandom_range(0, 49) == 0) ord = m_prev + 64'(2 + $urandom_range(0, 4));
         else ord = m_prev + 64'd1;
         rec = rnd_rec(ord);
         pop  = (mq.size() != 0) && rdy;
         push = v && ((mq.size() < DEPTH) || pop);
         cyc(v, rec, rdy);
         if (pop) void'(mq.pop_front());
         if (push) mq.push_back(rec);
         if (v && !push && m_drop < 65535) m_drop++;
         if (v) begin
            if (m_have && ord != m_prev + 64'd1) m_err = 1'b1;
            m_prev = ord;
            m_have = 1'b1;
         end
         chk("rnd_level", 166'(level_o), 166'(mq.size()));
         chk("rnd_valid", 166'(trace_valid_o), 166'(mq.size() != 0));
         chk("rnd_drop", 166'(drop_cnt_o), 166'(m_drop));
         chk("rnd_err", 166'(order_err_o), 166'(m_err & CHK_EN));
         if (mq.size() != 0) chk("rnd_head", trace_rec_o, mq[0]);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
